scr1_vec_banked_memory: RTL

- Parametrised, bank-interleaved successor to the core's dual-port TCM.
- LANES single-port banks; any LANES-word vector access, aligned or unaligned, completes in one cycle with no bank conflict.
- Port A: scalar instruction-fetch read. Port B: scalar byte-enabled read/write, or multi-beat vector read/write bursts driven by a small FSM.
- Sits between the SCR1 core / vector (NTT) datapath and on-chip RAM.

---
 rtl/scr1_vmem_pkg.sv | 27 ++
 rtl/scr1_vec_banked_memory_if.sv | 38 +++
 rtl/scr1_vmem_bank.sv | 43 ++++
 rtl/scr1_vec_banked_memory.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_vmem_pkg.sv
// Shared types and index helpers for the bank-interleaved vector memory.
package scr1_vmem_pkg;

  localparam int unsigned VMEM_WIDTH = 32;
  localparam int unsigned VMEM_LANES = 8;

  // One full vector (all lanes) at the default geometry.
  typedef logic [VMEM_LANES-1:0][VMEM_WIDTH-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RBURST = 2'd1,
    WBURST = 2'd2
  } vmem_state_e;

  // Bank holding a word: low address bits (lanes is a power of two).
  function automatic int unsigned vmem_bank_of(int unsigned word, int unsigned lanes);
    return word & (lanes - 1);
  endfunction

  // Row inside its bank: remaining address bits, wrapped to the bank depth.
  function automatic int unsigned vmem_row_of(int unsigned word, int unsigned lanes,
                                              int unsigned rows);
    return (word / lanes) & (rows - 1);
  endfunction

endpackage

// File: rtl/scr1_vec_banked_memory_if.sv
// Port A (fetch) and port B (scalar/vector) bus bundle of the banked memory.
interface scr1_vec_banked_memory_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 16,
  parameter int LANES = 8,
  parameter int LW    = 3
);
  logic                   a_req;
  logic [AW-3:0]          a_addr;
  logic                   a_gnt;
  logic                   a_rvalid;
  logic [WIDTH-1:0]       a_rdata;

  logic                   b_req;
  logic                   b_we;
  logic                   b_vec;
  logic [WIDTH/8-1:0]     b_be;
  logic [LW-1:0]          b_len;
  logic [AW-3:0]          b_addr;
  logic [LANES*WIDTH-1:0] b_wdata;
  logic                   b_wvalid;
  logic                   b_wready;
  logic                   b_gnt;
  logic                   b_rvalid;
  logic                   b_rlast;
  logic [LANES*WIDTH-1:0] b_rdata;
  logic                   b_busy;

  modport master (
    output a_req, a_addr, b_req, b_we, b_vec, b_be, b_len, b_addr, b_wdata, b_wvalid,
    input  a_gnt, a_rvalid, a_rdata, b_wready, b_gnt, b_rvalid, b_rlast, b_rdata, b_busy
  );

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_vec, b_be, b_len, b_addr, b_wdata, b_wvalid,
    output a_gnt, a_rvalid, a_rdata, b_wready, b_gnt, b_rvalid, b_rlast, b_rdata, b_busy
  );
endinterface

// File: rtl/scr1_vmem_bank.sv
// Single-port RAM bank: per-byte write enable, one-cycle registered read.
// Contents are never reset; only the read register is.
module scr1_vmem_bank #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [ROWS];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Byte-masked write into the array.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be[b]) mem[row][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read-first: an access captures the old word even when it also writes.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = mem[row];
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/scr1_vec_banked_memory.sv
// Bank-interleaved vector TCM. Word w lives in bank w mod LANES, so any
// LANES consecutive words hit every bank exactly once. Port B always wins a
// bank; port A is refused on a conflict and must hold its request.
// Optional macro SCR1_VMEM_PERF_EN adds saturating perf counters.
module scr1_vec_banked_memory
  import scr1_vmem_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIZE_BYTES = 65536,
  parameter int LANES      = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic clk,
  input  logic rst_n,
  scr1_vec_banked_memory_if.slave bus
`ifdef SCR1_VMEM_PERF_EN
  ,
  output logic [31:0] perf_a_stall,
  output logic [31:0] perf_b_beats
`endif
);
  localparam int NBYTES = WIDTH / 8;
  localparam int AW     = $clog2(SIZE_BYTES);
  localparam int WORDS  = SIZE_BYTES / NBYTES;
  localparam int ROWS   = WORDS / LANES;
  localparam int LW     = $clog2(MAX_BURST);
  localparam int WAW    = AW - 2;
  localparam int RW     = $clog2(ROWS);
  localparam int BW     = $clog2(LANES);

  vmem_state_e      state_q, state_d;
  logic [WAW-1:0]   base_q, base_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    k_q, k_d;

  logic             a_rvalid_q, a_rvalid_d;
  logic [BW-1:0]    a_bank_q, a_bank_d;
  logic [WIDTH-1:0] a_hold_q, a_hold_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic             b_rlast_q, b_rlast_d;
  logic             b_rvec_q, b_rvec_d;
  logic [BW-1:0]    b_rot_q, b_rot_d;
  logic [LANES*WIDTH-1:0] b_hold_q, b_hold_d;

  logic             s_acc, v_acc, acc_we, rd_issue, rd_last;
  logic [WAW-1:0]   acc_addr, beat_off;
  logic [BW-1:0]    a_bank, s_bank;
  logic             a_conflict;
  logic [WIDTH-1:0] a_rdata_c;
  logic [LANES*WIDTH-1:0] b_rdata_c;

  logic             bank_en    [LANES];
  logic             bank_we    [LANES];
  logic [NBYTES-1:0] bank_be   [LANES];
  logic [RW-1:0]    bank_row   [LANES];
  logic [WIDTH-1:0] bank_wdata [LANES];
  logic [WIDTH-1:0] bank_rdata [LANES];
  logic [BW-1:0]    lane_of_bank [LANES];
  logic [WAW-1:0]   word_of_bank [LANES];

  // Port B FSM: decides this cycle's B access and the next burst state.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    k_d       = k_q;
    s_acc     = 1'b0;
    v_acc     = 1'b0;
    acc_we    = 1'b0;
    rd_issue  = 1'b0;
    rd_last   = 1'b0;
    acc_addr  = bus.b_addr;
    beat_off  = WAW'(k_q) << BW;
    bus.b_gnt    = 1'b0;
    bus.b_wready = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.b_req && rst_n) begin
          bus.b_gnt = 1'b1;
          if (!bus.b_vec) begin
            s_acc    = 1'b1;
            acc_we   = bus.b_we;
            rd_issue = !bus.b_we;
            rd_last  = 1'b1;
          end else if (!bus.b_we) begin
            v_acc    = 1'b1;
            rd_issue = 1'b1;
            rd_last  = (bus.b_len == '0);
            if (bus.b_len != '0) begin
              state_d = RBURST;
              base_d  = bus.b_addr;
              len_d   = bus.b_len;
              k_d     = LW'(1);
            end
          end else begin
            state_d = WBURST;
            base_d  = bus.b_addr;
            len_d   = bus.b_len;
            k_d     = '0;
          end
        end
      end
      RBURST: begin
        v_acc    = 1'b1;
        acc_addr = base_q + beat_off;
        rd_issue = 1'b1;
        rd_last  = (k_q == len_q);
        k_d      = k_q + LW'(1);
        if (k_q == len_q) state_d = IDLE;
      end
      WBURST: begin
        bus.b_wready = 1'b1;
        acc_addr     = base_q + beat_off;
        if (bus.b_wvalid) begin
          v_acc  = 1'b1;
          acc_we = 1'b1;
          k_d    = k_q + LW'(1);
          if (k_q == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.b_busy = (state_q != IDLE);

  // Port A arbitration: a vector beat owns every bank, a scalar B access one.
  always_comb begin
    a_bank     = BW'(vmem_bank_of(32'(bus.a_addr), LANES));
    s_bank     = BW'(vmem_bank_of(32'(acc_addr), LANES));
    a_conflict = v_acc | (s_acc & (s_bank == a_bank));
    bus.a_gnt  = bus.a_req & ~a_conflict & rst_n;
  end

  // Lane-to-bank rotation: bank j serves lane (j - base) mod LANES.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_of_bank[j] = BW'(j) - acc_addr[BW-1:0];
      word_of_bank[j] = acc_addr + WAW'(lane_of_bank[j]);
    end
  end

  // Bank port steering: B first, then A on whatever bank is free.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      bank_en[j]    = 1'b0;
      bank_we[j]    = 1'b0;
      bank_be[j]    = '0;
      bank_row[j]   = '0;
      bank_wdata[j] = '0;
      if (v_acc) begin
        bank_en[j]    = 1'b1;
        bank_we[j]    = acc_we & rst_n;
        bank_be[j]    = '1;
        bank_row[j]   = RW'(vmem_row_of(32'(word_of_bank[j]), LANES, ROWS));
        bank_wdata[j] = bus.b_wdata[int'(lane_of_bank[j])*WIDTH +: WIDTH];
      end else if (s_acc && (s_bank == BW'(j))) begin
        bank_en[j]    = 1'b1;
        bank_we[j]    = acc_we & rst_n;
        bank_be[j]    = bus.b_be;
        bank_row[j]   = RW'(vmem_row_of(32'(acc_addr), LANES, ROWS));
        bank_wdata[j] = bus.b_wdata[WIDTH-1:0];
      end else if (bus.a_gnt && (a_bank == BW'(j))) begin
        bank_en[j]    = 1'b1;
        bank_row[j]   = RW'(vmem_row_of(32'(bus.a_addr), LANES, ROWS));
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    scr1_vmem_bank #(.WIDTH(WIDTH), .ROWS(ROWS)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bank_en[g]),
      .we    (bank_we[g]),
      .be    (bank_be[g]),
      .row   (bank_row[g]),
      .wdata (bank_wdata[g]),
      .rdata (bank_rdata[g])
    );
  end

  // Read return tracking: which bank/rotation the next-cycle data comes from.
  always_comb begin
    a_rvalid_d = bus.a_gnt;
    a_bank_d   = bus.a_gnt ? a_bank : a_bank_q;
    b_rvalid_d = rd_issue;
    b_rlast_d  = rd_issue & rd_last;
    b_rvec_d   = rd_issue ? v_acc : b_rvec_q;
    b_rot_d    = rd_issue ? acc_addr[BW-1:0] : b_rot_q;
  end

  // Read data un-rotation; outputs hold their last value between reads.
  always_comb begin
    a_rdata_c = a_rvalid_q ? bank_rdata[a_bank_q] : a_hold_q;
    b_rdata_c = b_hold_q;
    if (b_rvalid_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (b_rvec_q || (i == 0)) b_rdata_c[i*WIDTH +: WIDTH] = bank_rdata[b_rot_q + BW'(i)];
        else                      b_rdata_c[i*WIDTH +: WIDTH] = '0;
      end
    end
    a_hold_d = a_rdata_c;
    b_hold_d = b_rdata_c;
  end

  // Control and read-return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      k_q        <= '0;
      a_rvalid_q <= 1'b0;
      a_bank_q   <= '0;
      a_hold_q   <= '0;
      b_rvalid_q <= 1'b0;
      b_rlast_q  <= 1'b0;
      b_rvec_q   <= 1'b0;
      b_rot_q    <= '0;
      b_hold_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      k_q        <= k_d;
      a_rvalid_q <= a_rvalid_d;
      a_bank_q   <= a_bank_d;
      a_hold_q   <= a_hold_d;
      b_rvalid_q <= b_rvalid_d;
      b_rlast_q  <= b_rlast_d;
      b_rvec_q   <= b_rvec_d;
      b_rot_q    <= b_rot_d;
      b_hold_q   <= b_hold_d;
    end
  end

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rdata_c;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rlast  = b_rlast_q;
  assign bus.b_rdata  = b_rdata_c;

`ifdef SCR1_VMEM_PERF_EN
  logic [31:0] perf_a_stall_q, perf_a_stall_d;
  logic [31:0] perf_b_beats_q, perf_b_beats_d;

  // Saturating counters: refused A cycles and vector beats moved on B.
  always_comb begin
    perf_a_stall_d = perf_a_stall_q;
    perf_b_beats_d = perf_b_beats_q;
    if (bus.a_req && !bus.a_gnt && (perf_a_stall_q != '1)) perf_a_stall_d = perf_a_stall_q + 32'd1;
    if (v_acc && (perf_b_beats_q != '1))                   perf_b_beats_d = perf_b_beats_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_a_stall_q <= '0;
      perf_b_beats_q <= '0;
    end else begin
      perf_a_stall_q <= perf_a_stall_d;
      perf_b_beats_q <= perf_b_beats_d;
    end
  end

  assign perf_a_stall = perf_a_stall_q;
  assign perf_b_beats = perf_b_beats_q;
`endif
endmodule
